// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs RATIO consecutive DSIZE-bit words into one wide
// valid/ready output word with a lane-keep mask; flush drains a partial word.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CW-1:0]          lane_cnt,
    output logic                   busy
);

    localparam int            W    = DSIZE * RATIO;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [W-1:0]     acc;
    logic             flush_pend;
    logic             slot_free;
    logic             flush_eff;
    logic             last_lane;
    logic             service;
    logic [RATIO-1:0] part_keep;

    assign slot_free = !m_valid | m_ready;
    assign flush_eff = flush | flush_pend;
    assign last_lane = (lane_cnt == LAST);
    assign service   = flush_eff & slot_free;
    // A pop that completes a word needs somewhere to put it; flush blocks all pops.
    assign rinc      = !rrst & !rempty & !flush_eff & (!last_lane | slot_free);
    assign busy      = (lane_cnt != '0) | m_valid | flush_pend;

    always_comb begin
        part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            part_keep[i] = (CW'(i) < lane_cnt);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            acc        <= '0;
            lane_cnt   <= '0;
            flush_pend <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_valid    <= 1'b0;
        end else begin
            // Accept clears valid; a load later in this block overrides it.
            if (m_valid & m_ready) begin
                m_valid <= 1'b0;
            end

            if (service) begin
                flush_pend <= 1'b0;
                if (lane_cnt != '0) begin
                    m_data   <= acc;
                    m_keep   <= part_keep;
                    m_valid  <= 1'b1;
                    acc      <= '0;
                    lane_cnt <= '0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end

            // rinc and service are mutually exclusive (rinc requires !flush_eff).
            if (rinc) begin
                if (last_lane) begin
                    m_data   <= {rdata, acc[W-DSIZE-1:0]};
                    m_keep   <= '1;
                    m_valid  <= 1'b1;
                    acc      <= '0;
                    lane_cnt <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (lane_cnt == CW'(i)) begin
                            acc[i*DSIZE +: DSIZE] <= rdata;
                        end
                    end
                    lane_cnt <= lane_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-modelled FIFO, scoreboard of expected output
// words built from the popped byte stream, plus directed corner sequences.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;
    localparam int CW    = $clog2(RATIO + 1);
    localparam int W     = DSIZE * RATIO;

    logic             rclk;
    logic             rrst;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             flush;
    logic [W-1:0]     m_data;
    logic [RATIO-1:0] m_keep;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    lane_cnt;
    logic             busy;

    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
        .m_ready(m_ready), .lane_cnt(lane_cnt), .busy(busy)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    typedef struct {
        logic [W-1:0]     data;
        logic [RATIO-1:0] keep;
    } exp_t;

    typedef struct {
        logic [7:0]   b0, b1, b2, b3;
        logic [W-1:0] exp;
    } vec_t;

    logic [DSIZE-1:0] fifo_q[$];
    exp_t             exp_q[$];
    logic [W-1:0]     macc;
    int               mcnt;
    int               checks;
    int               errors;
    int               pops;
    vec_t             vecs[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    task automatic push(input logic [DSIZE-1:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    function automatic void model_clear();
        macc = '0;
        mcnt = 0;
    endfunction

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h expected no word", m_data);
        end else begin
            e = exp_q.pop_front();
            chk("sb_data", m_data, e.data);
            chk("sb_keep", m_keep, e.keep);
        end
    endtask

    // One clock: sample handshakes just before the edge, update FIFO model after it.
    task automatic tick();
        logic pop, acc_now;
        logic [DSIZE-1:0] b;
        exp_t e;
        #1;
        pop     = rinc;
        acc_now = m_valid & m_ready;
        if (acc_now) check_out();
        @(posedge rclk);
        #1;
        if (pop && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            pops++;
            macc[mcnt*DSIZE +: DSIZE] = b;
            mcnt++;
            if (mcnt == RATIO) begin
                e.data = macc;
                e.keep = '1;
                exp_q.push_back(e);
                model_clear();
            end
        end
        refresh();
    endtask

    task automatic do_flush();
        exp_t e;
        if (mcnt > 0) begin
            e.data = macc;
            e.keep = RATIO'((1 << mcnt) - 1);
            exp_q.push_back(e);
            model_clear();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int p0;
        bit seen;
        checks = 0;
        errors = 0;
        pops   = 0;
        model_clear();
        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        vecs[1] = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 32'h5AA500FF};
        vecs[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        refresh();
        @(posedge rclk);
        @(posedge rclk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_lane", lane_cnt, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_busy", busy, 0);
        rrst = 1'b0;

        // Basic pack
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        p0 = pops;
        for (int i = 0; i < 4; i++) tick();
        chk("basic_pops", pops - p0, 4);
        chk("basic_valid", m_valid, 1);
        chk("basic_data", m_data, 32'h44332211);
        chk("basic_keep", m_keep, 4'hF);
        tick();
        chk("basic_valid_drop", m_valid, 0);
        chk("basic_busy", busy, 0);

        // Table vectors
        for (int v = 0; v < 3; v++) begin
            push(vecs[v].b0); push(vecs[v].b1); push(vecs[v].b2); push(vecs[v].b3);
            seen = 0;
            for (int t = 0; t < 10 && !seen; t++) begin
                tick();
                if (m_valid) seen = 1;
            end
            chk("vec_timeout", seen, 1);
            chk("vec_data", m_data, vecs[v].exp);
            chk("vec_keep", m_keep, 4'hF);
            tick();
        end

        // Back-pressure with 9 words
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push(DSIZE'(i * 8'h11));
        for (int i = 0; i < 8; i++) tick();
        #1;
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 32'h44332211);
        chk("bp_lane", lane_cnt, 3);
        chk("bp_rinc", rinc, 0);
        m_ready = 1'b1;
        tick();
        chk("bp_valid_hold", m_valid, 1);
        chk("bp_data2", m_data, 32'h88776655);
        tick();
        chk("bp_lane9", lane_cnt, 1);
        chk("bp_valid_drop", m_valid, 0);
        do_flush();
        chk("bp_flush_data", m_data, 32'h00000099);
        chk("bp_flush_keep", m_keep, 4'b0001);
        tick();

        // Partial flush
        push(8'hAA); push(8'hBB);
        tick(); tick();
        chk("pf_lane", lane_cnt, 2);
        chk("pf_empty", rempty, 1);
        do_flush();
        chk("pf_valid", m_valid, 1);
        chk("pf_data", m_data, 32'h0000BBAA);
        chk("pf_keep", m_keep, 4'b0011);
        chk("pf_lane0", lane_cnt, 0);
        tick();
        chk("pf_busy", busy, 0);

        // Flush while stalled
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DSIZE'(i));
        for (int i = 0; i < 5; i++) tick();
        chk("fs_lane", lane_cnt, 1);
        chk("fs_valid", m_valid, 1);
        do_flush();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fs_rinc_blocked", rinc, 0);
            chk("fs_busy", busy, 1);
            tick();
        end
        chk("fs_lane_hold", lane_cnt, 1);
        m_ready = 1'b1;
        #1;
        chk("fs_rinc_pend", rinc, 0);
        tick();
        chk("fs_valid2", m_valid, 1);
        chk("fs_data", m_data, 32'h00000005);
        chk("fs_keep", m_keep, 4'b0001);
        chk("fs_lane0", lane_cnt, 0);
        #1;
        chk("fs_resume", rinc, 1);
        tick();
        chk("fs_lane_resume", lane_cnt, 1);
        do_flush();
        tick();

        // Empty flush
        chk("ef_pre_busy", busy, 0);
        do_flush();
        chk("ef_valid", m_valid, 0);
        chk("ef_busy", busy, 0);
        tick();
        chk("ef_valid2", m_valid, 0);

        // Reset mid-word
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DSIZE'(8'h70 + i));
        for (int i = 0; i < 6; i++) tick();
        chk("rm_pre_lane", lane_cnt, 2);
        chk("rm_pre_valid", m_valid, 1);
        #2;
        rrst = 1'b1;
        #1;
        chk("rm_valid", m_valid, 0);
        chk("rm_data", m_data, 0);
        chk("rm_keep", m_keep, 0);
        chk("rm_lane", lane_cnt, 0);
        chk("rm_rinc", rinc, 0);
        exp_q.delete();
        model_clear();
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        m_ready = 1'b1;
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        for (int i = 0; i < 4; i++) tick();
        chk("rm_fresh_data", m_data, 32'hC3C2C1C0);
        chk("rm_fresh_keep", m_keep, 4'hF);
        tick();

        chk("end_sb_empty", exp_q.size(), 0);
        chk("end_fifo_empty", fifo_q.size(), 0);
        chk("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
